// File: rtl/ov9281_sccb_target.sv
// ov9281_sccb_target
//   SCCB/I2C target that emulates the OV9281 control port. It decodes a 7-bit
//   device address, a 16-bit register pointer (high byte first) and 8-bit data
//   bytes. Register accesses are presented as a simple strobe port.
//
//   Optional build macro: OV9281_TGT_FILTER_EN adds a FILTER_LEN-sample
//   glitch filter after the input synchronizers.
//
// Parameters
//   DEV_ADDR    7-bit target address (default 7'h60)
//   FILTER_LEN  stable-sample count of the glitch filter
// Ports
//   i_clk, i_rst   system clock, asynchronous active-high reset
//   i_scl_in       SCL bus level
//   i_sda_in       SDA bus level
//   o_sda_out      pad output level, always 0 (open drain)
//   o_sda_oe       1 = pull SDA low
//   o_reg_addr     16-bit register pointer
//   o_reg_wdata    write data, valid with o_reg_we
//   o_reg_we       one-cycle write strobe
//   o_reg_re       one-cycle read strobe; i_reg_rdata captured in that cycle
//   i_reg_rdata    read data, combinational from o_reg_addr
//   o_busy         addressed transaction in progress
module ov9281_sccb_target #(
  parameter logic [6:0]  DEV_ADDR   = 7'h60,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_scl_in,
  input  logic        i_sda_in,
  output logic        o_sda_out,
  output logic        o_sda_oe,
  output logic [15:0] o_reg_addr,
  output logic [7:0]  o_reg_wdata,
  output logic        o_reg_we,
  output logic        o_reg_re,
  input  logic [7:0]  i_reg_rdata,
  output logic        o_busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV,
    S_DEV_ACK,
    S_AH,
    S_AH_ACK,
    S_AL,
    S_AL_ACK,
    S_WR,
    S_WR_ACK,
    S_RD,
    S_RD_MACK,
    S_IGNORE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers (idle bus level is high)
  // ---------------------------------------------------------------------------
  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_f;
  logic       sda_f;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], i_scl_in};
      sda_sync_q <= {sda_sync_q[0], i_sda_in};
    end
  end

`ifdef OV9281_TGT_FILTER_EN
  localparam int unsigned CNT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [CNT_W-1:0] scl_cnt_q, scl_cnt_d;
  logic [CNT_W-1:0] sda_cnt_q, sda_cnt_d;
  logic             scl_flt_q, scl_flt_d;
  logic             sda_flt_q, sda_flt_d;

  // Each line follows its synchronizer only after FILTER_LEN consecutive
  // samples that differ from the current filtered level.
  always_comb begin
    scl_flt_d = scl_flt_q;
    scl_cnt_d = '0;
    if (scl_sync_q[1] != scl_flt_q) begin
      if (scl_cnt_q == CNT_LAST) scl_flt_d = scl_sync_q[1];
      else                       scl_cnt_d = scl_cnt_q + CNT_W'(1);
    end
    sda_flt_d = sda_flt_q;
    sda_cnt_d = '0;
    if (sda_sync_q[1] != sda_flt_q) begin
      if (sda_cnt_q == CNT_LAST) sda_flt_d = sda_sync_q[1];
      else                       sda_cnt_d = sda_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_flt_q <= 1'b1;
      sda_flt_q <= 1'b1;
      scl_cnt_q <= '0;
      sda_cnt_q <= '0;
    end else begin
      scl_flt_q <= scl_flt_d;
      sda_flt_q <= sda_flt_d;
      scl_cnt_q <= scl_cnt_d;
      sda_cnt_q <= sda_cnt_d;
    end
  end

  assign scl_f = scl_flt_q;
  assign sda_f = sda_flt_q;
`else
  logic unused_filter_len;
  assign unused_filter_len = ^FILTER_LEN;
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif

  // ---------------------------------------------------------------------------
  // Edge / bus-condition detection
  // ---------------------------------------------------------------------------
  logic scl_prev_q;
  logic sda_prev_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
    end
  end

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  assign scl_rise  =  scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f &  scl_prev_q;
  assign start_det =  scl_f &  scl_prev_q &  sda_prev_q & ~sda_f;
  assign stop_det  =  scl_f &  scl_prev_q & ~sda_prev_q &  sda_f;

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  state_t      state_q,   state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q,   shift_d;
  logic [7:0]  ah_q,      ah_d;
  logic [15:0] addr_q,    addr_d;
  logic [7:0]  wdata_q,   wdata_d;
  logic        we_q,      we_d;
  logic        inc_q,     inc_d;
  logic        sda_oe_q,  sda_oe_d;
  logic        busy_q,    busy_d;
  logic        rw_q,      rw_d;
  // ACK states: 0 = waiting for the fall that starts driving ACK,
  // 1 = ACK driven, next fall ends it. RD_MACK: 1 = initiator ACK seen.
  logic        phase_q,   phase_d;
  logic        rd_load;
  logic [7:0]  rx_byte;

  assign rx_byte = {shift_q[6:0], sda_f};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ah_d      = ah_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    phase_d   = phase_q;
    rd_load   = 1'b0;

    // Pointer advances the cycle after each write or read strobe.
    if (we_q || inc_q) addr_d = addr_q + 16'd1;

    if (start_det) begin
      state_d   = S_DEV;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      phase_d   = 1'b0;
    end else if (stop_det) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      phase_d  = 1'b0;
    end else begin
      case (state_q)
        S_DEV, S_AH, S_AL, S_WR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              phase_d   = 1'b0;
              case (state_q)
                S_DEV: begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state_d = S_DEV_ACK;
                    rw_d    = rx_byte[0];
                    busy_d  = 1'b1;
                  end else begin
                    state_d = S_IGNORE;
                    busy_d  = 1'b0;
                  end
                end
                S_AH: begin
                  ah_d    = rx_byte;
                  state_d = S_AH_ACK;
                end
                S_AL: begin
                  addr_d  = {ah_q, rx_byte};
                  state_d = S_AL_ACK;
                end
                default: begin
                  wdata_d = rx_byte;
                  we_d    = 1'b1;
                  state_d = S_WR_ACK;
                end
              endcase
            end
          end
        end

        S_DEV_ACK, S_AH_ACK, S_AL_ACK, S_WR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              phase_d   = 1'b0;
              bit_cnt_d = '0;
              case (state_q)
                S_DEV_ACK: begin
                  if (rw_q) rd_load = 1'b1;
                  else      state_d = S_AH;
                end
                S_AH_ACK: state_d = S_AL;
                default:  state_d = S_WR;
              endcase
            end
          end
        end

        S_RD: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d  = S_RD_MACK;
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end

        S_RD_MACK: begin
          if (scl_rise) begin
            if (sda_f) state_d = S_IGNORE;
            else       phase_d = 1'b1;
          end else if (scl_fall && phase_q) begin
            phase_d = 1'b0;
            rd_load = 1'b1;
          end
        end

        default: ;
      endcase

      // Read strobe and data capture share the cycle, so the first data bit
      // goes out with the same latency as an ACK.
      if (rd_load) begin
        state_d   = S_RD;
        bit_cnt_d = '0;
        shift_d   = i_reg_rdata;
        sda_oe_d  = ~i_reg_rdata[7];
      end
    end

    inc_d = rd_load;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ah_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      inc_q     <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      phase_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ah_q      <= ah_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      inc_q     <= inc_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
      phase_q   <= phase_d;
    end
  end

  assign o_sda_out   = 1'b0;
  assign o_sda_oe    = sda_oe_q;
  assign o_reg_addr  = addr_q;
  assign o_reg_wdata = wdata_q;
  assign o_reg_we    = we_q;
  assign o_reg_re    = rd_load;
  assign o_busy      = busy_q;

endmodule

// File: doc/ov9281_sccb_target.md
# ov9281_sccb_target

I2C/SCCB target (responder) emulating the OV9281 sensor's control interface: it decodes a 7-bit device address, a 16-bit register address and 8-bit data, and exposes a simple register-port handshake to a register file. It sits opposite the camera configuration initiator on the same open-drain bus. It serves as the sensor model in simulation and FPGA loopback, and as the slave port for on-chip camera-control registers.

## Interface
- DEV_ADDR, 7'h60, 7-bit target address (OV9281 default).
- FILTER_LEN, 4, stable-sample count for the input glitch filter. Unused without the filter macro.
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_scl_in  in  1  SCL bus level.
- i_sda_in  in  1  SDA bus level.
- o_sda_out  out  1  constant 0. The pad drives low only when o_sda_oe=1.
- o_sda_oe  out  1  1 = pull SDA low.
- o_reg_addr  out  16  register pointer.
- o_reg_wdata  out  8  write data, valid with o_reg_we.
- o_reg_we  out  1  one-cycle write strobe.
- o_reg_re  out  1  one-cycle read strobe. i_reg_rdata is captured in the same cycle.
- i_reg_rdata  in  8  read data, combinational from o_reg_addr.
- o_busy  out  1  high from address match to STOP, repeated START to a different address, or reset.

## Operation
- SCL and SDA pass through a 2-flop synchronizer, then the optional filter.
  - The edge detector produces scl_rise and scl_fall.
  - START = SDA falls while SCL is high.
  - STOP = SDA rises while SCL is high.
- Bits are sampled on scl_rise, MSB first. SDA changes (ACK, read data) occur on scl_fall.
- States: IDLE, DEV, DEV_ACK, AH, AH_ACK, AL, AL_ACK, WR, WR_ACK, RD, RD_MACK, IGNORE.
- Any START from any state goes to DEV: bit counter cleared, SDA released.
- STOP from any state goes to IDLE: SDA released, o_busy=0.
- DEV: 8 bits received. {DEV_ADDR,rw} match goes to DEV_ACK. A mismatch goes to IGNORE (no ACK, SDA never driven).
- Write path: DEV_ACK (rw=0) → AH → AH_ACK → AL → AL_ACK → WR → WR_ACK → WR …
  - The pointer loads {AH,AL} at the end of AL.
  - Each complete WR byte gives o_reg_wdata=byte and a one-cycle o_reg_we pulse on the scl_rise of bit 0.
  - o_reg_addr increments the following cycle.
- Read path: DEV_ACK (rw=1) → RD. Current-address read uses the existing pointer.
  - On the scl_fall ending the ACK, o_reg_re pulses and i_reg_rdata is latched into the shift register.
  - o_reg_addr increments the next cycle.
  - Bits are driven as o_sda_oe = ~bit.
- RD_MACK: SDA released, initiator ACK/NACK sampled.
  - ACK (0): back to RD with the next byte loaded on the following scl_fall.
  - NACK (1): IGNORE until STOP/START.
- ACK: o_sda_oe=1 from the scl_fall after the 8th bit to the next scl_fall.
- Pointer arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000.
- A partial byte aborted by START/STOP produces no o_reg_we and no pointer change.
- A write with only AH received leaves the pointer unchanged.

## Timing
- All outputs reset to 0: o_sda_out, o_sda_oe, o_reg_addr, o_reg_wdata, o_reg_we, o_reg_re, o_busy. State resets to IDLE.
- Reset mid-transfer releases SDA asynchronously. The bus transaction is lost.
- Input latency: 2 cycles without filter, 2+FILTER_LEN with filter.
- SDA drive change lags the pin SCL fall by input latency +1 cycle.
- SCL high and low phases must each be ≥ input latency + 3 cycles. Example: 50 MHz with 400 kHz SCL meets this.
- i_reg_rdata must be valid in the cycle o_reg_re=1. o_reg_addr is stable ≥1 cycle before the strobe.
- o_reg_we and o_reg_re are never high in the same cycle.
- No clock stretching; SCL is never driven.

## Configuration
- OV9281_TGT_FILTER_EN defined: each synchronized line updates only after FILTER_LEN consecutive identical samples. Pulses shorter than FILTER_LEN cycles are suppressed.
- OV9281_TGT_FILTER_EN undefined: synchronizer output is used directly. FILTER_LEN is ignored.

## Test plan
- Write S,0xC0,0x30,0x0A,0x5A,0xA5,P.
  - ACK on all 5 bytes.
  - o_reg_we pulses twice: addr 0x300A/data 0x5A, then 0x300B/0xA5.
  - Final o_reg_addr=0x300C and o_busy=0 after P.
- Random read S,0xC0,0x30,0x0A,Sr,0xC1, 2 bytes (ACK, NACK), P, with the model returning addr[7:0].
  - Bytes read are 0x0A and 0x0B.
  - Exactly 2 o_reg_re pulses.
- Address 0xC2: SDA never pulled low, no strobes, o_busy stays 0.
- Write at pointer 0xFFFF with 2 bytes: writes go to 0xFFFF then 0x0000.
- START injected after 4 bits of a WR byte, then a new write: no o_reg_we from the aborted byte.
- With OV9281_TGT_FILTER_EN: 2-cycle SCL glitch mid-bit produces no extra bit and data is unchanged. Without the macro, the same glitch corrupts the byte.
